// File: rtl/encoder_layer_1_intermediate_dense_dot_accum.sv
// Fixed-point dot-product accumulator: pairs activation and weight beats, sums lane products
// over IN_DEPTH beats and presents one full-precision result through a valid/ready register.
module encoder_layer_1_intermediate_dense_dot_accum #(
    parameter int DATA_IN_0_PRECISION_0  = 16,
    parameter int DATA_IN_0_PRECISION_1  = 3,
    parameter int WEIGHT_PRECISION_0     = 16,
    parameter int WEIGHT_PRECISION_1     = 3,
    parameter int PARALLELISM            = 4,
    parameter int IN_DEPTH               = 8,
    parameter int DATA_OUT_0_PRECISION_0 = DATA_IN_0_PRECISION_0 + WEIGHT_PRECISION_0
                                           + $clog2(PARALLELISM * IN_DEPTH),
    parameter int DATA_OUT_0_PRECISION_1 = DATA_IN_0_PRECISION_1 + WEIGHT_PRECISION_1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DATA_IN_0_PRECISION_0-1:0]  data_in_0 [PARALLELISM],
    input  logic                              data_in_0_valid,
    output logic                              data_in_0_ready,
    input  logic [WEIGHT_PRECISION_0-1:0]     weight [PARALLELISM],
    input  logic                              weight_valid,
    output logic                              weight_ready,
    output logic [DATA_OUT_0_PRECISION_0-1:0] data_out_0,
    output logic                              data_out_0_valid,
    input  logic                              data_out_0_ready
);

    localparam int PW = DATA_IN_0_PRECISION_0 + WEIGHT_PRECISION_0;
    localparam int OW = DATA_OUT_0_PRECISION_0;
    localparam int CW = $clog2(IN_DEPTH) + 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(IN_DEPTH - 1);

    // Elaboration-time sanity on the parameter set; no hardware results.
    if (IN_DEPTH < 1) begin : g_bad_depth
        $error("IN_DEPTH must be at least 1");
    end
    if (DATA_OUT_0_PRECISION_1 != DATA_IN_0_PRECISION_1 + WEIGHT_PRECISION_1) begin : g_bad_frac
        $error("result fractional bits must equal activation plus weight fractional bits");
    end
    if (OW < PW) begin : g_bad_width
        $error("result width narrower than a single product");
    end

    logic [CW-1:0]        cnt;
    logic signed [OW-1:0] acc;
    logic signed [OW-1:0] beat_sum;
    logic signed [PW-1:0] prod [PARALLELISM];
    logic                 last_beat;
    logic                 can_step;
    logic                 fire;

    always_comb begin
        beat_sum = '0;
        for (int i = 0; i < PARALLELISM; i++) begin
            prod[i]  = PW'($signed(data_in_0[i])) * PW'($signed(weight[i]));
            beat_sum = beat_sum + OW'(prod[i]);
        end
    end

    // Only the closing beat needs room in the output register.
    assign last_beat       = (cnt == LAST_BEAT);
    assign can_step        = !last_beat | !data_out_0_valid | data_out_0_ready;
    assign fire            = data_in_0_valid & weight_valid & can_step;
    assign data_in_0_ready = weight_valid & can_step;
    assign weight_ready    = data_in_0_valid & can_step;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt              <= '0;
            acc              <= '0;
            data_out_0       <= '0;
            data_out_0_valid <= 1'b0;
        end else begin
            if (data_out_0_valid & data_out_0_ready) begin
                data_out_0_valid <= 1'b0;
            end
            if (fire) begin
                if (last_beat) begin
                    data_out_0       <= acc + beat_sum;
                    data_out_0_valid <= 1'b1;
                    acc              <= '0;
                    cnt              <= '0;
                end else begin
                    acc <= acc + beat_sum;
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

endmodule
